// File: rtl/rip_pseudo_core_launcher.sv
// Job launcher for the RIP pseudo core.
// Start addresses are queued in a small FIFO and handed to the core one at a time
// on mem_head. Each job ends with a one-cycle done pulse that reports ok,
// timeout or invalid address.
module rip_pseudo_core_launcher #(
    parameter int ADDR_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [ADDR_WIDTH-1:0]       cmd_addr,
    output logic [ADDR_WIDTH-1:0]       mem_head,
    input  logic [1:0]                  busy,
    output logic                        done_valid,
    output logic [ADDR_WIDTH-1:0]       done_addr,
    output logic [1:0]                  done_status,
    output logic [15:0]                 done_count,
    output logic [$clog2(FIFO_DEPTH):0] pending,
    output logic                        idle
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [ADDR_WIDTH-1:0] NO_JOB   = '1;
    localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [TMR_W-1:0]      TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_TIMEOUT  = 2'b01;
    localparam logic [1:0] ST_BAD_ADDR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN
    } state_t;

    state_t state, state_d;

    logic [ADDR_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  push, pop;

    logic [ADDR_WIDTH-1:0] head_addr;
    logic                  head_bad;
    logic [ADDR_WIDTH-1:0] job_addr, job_addr_d;
    logic [TMR_W-1:0]      timer, timer_d;
    logic                  timeout_hit;

    logic [ADDR_WIDTH-1:0] head_d;
    logic                  done_valid_d;
    logic [ADDR_WIDTH-1:0] done_addr_d;
    logic [1:0]            done_status_d;
    logic                  count_inc;

    // Ready depends only on registered occupancy, so there is no path from pop to cmd_ready.
    assign cmd_ready = (count != FULL_CNT);
    assign push      = cmd_valid && cmd_ready;
    assign pending   = count;
    assign idle      = (state == S_IDLE) && (count == '0);

    // The core ORs cnt<<2 into bits [9:2], so a usable base address has its low 10 bits clear.
    assign head_addr   = fifo_mem[rd_ptr];
    assign head_bad    = (head_addr == NO_JOB) || (head_addr[9:0] != 10'd0);
    assign timeout_hit = (state != S_IDLE) && (timer == TMR_LAST);

    // Queue storage: write on push.
    // NOTE: no reset on the storage array; count decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= cmd_addr;
    end

    // Queue pointers and occupancy.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_d;
    end

    // Next state, pop decision, and next values of the registered outputs.
    // NOTE: every output gets a default first, so no path through the case infers a latch.
    always_comb begin
        state_d       = state;
        pop           = 1'b0;
        job_addr_d    = job_addr;
        timer_d       = timer;
        head_d        = mem_head;
        done_valid_d  = 1'b0;
        done_addr_d   = done_addr;
        done_status_d = done_status;
        count_inc     = 1'b0;
        case (state)
            S_IDLE: begin
                if ((count != '0) && (busy == 2'b00)) begin
                    pop        = 1'b1;
                    job_addr_d = head_addr;
                    timer_d    = '0;
                    if (head_bad) begin
                        done_valid_d  = 1'b1;
                        done_addr_d   = head_addr;
                        done_status_d = ST_BAD_ADDR;
                    end else begin
                        head_d  = head_addr;
                        state_d = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                if (timeout_hit) begin
                    head_d        = NO_JOB;
                    done_valid_d  = 1'b1;
                    done_addr_d   = job_addr;
                    done_status_d = ST_TIMEOUT;
                    state_d       = S_IDLE;
                end else begin
                    timer_d = timer + 1'b1;
                    // Hold the head until the core has left INIT.
                    if (busy[1]) begin
                        head_d  = NO_JOB;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (timeout_hit) begin
                    head_d        = NO_JOB;
                    done_valid_d  = 1'b1;
                    done_addr_d   = job_addr;
                    done_status_d = ST_TIMEOUT;
                    state_d       = S_IDLE;
                end else if (busy == 2'b00) begin
                    done_valid_d  = 1'b1;
                    done_addr_d   = job_addr;
                    done_status_d = ST_OK;
                    count_inc     = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    timer_d = timer + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registered job datapath and outputs; reset drops mem_head to all-ones right away.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_head    <= NO_JOB;
            job_addr    <= '0;
            timer       <= '0;
            done_valid  <= 1'b0;
            done_addr   <= '0;
            done_status <= ST_OK;
            done_count  <= 16'd0;
        end else begin
            mem_head    <= head_d;
            job_addr    <= job_addr_d;
            timer       <= timer_d;
            done_valid  <= done_valid_d;
            done_addr   <= done_addr_d;
            done_status <= done_status_d;
            if (count_inc) done_count <= done_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_rip_pseudo_core_launcher.sv
// Directed bench for rip_pseudo_core_launcher.
// The main instance uses the default parameters. A second instance uses
// TIMEOUT_CYCLES=16 for the abort scenario. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_rip_pseudo_core_launcher;

    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    logic        clk;
    logic        rstn;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [31:0] mem_head;
    logic [1:0]  busy;
    logic        done_valid;
    logic [31:0] done_addr;
    logic [1:0]  done_status;
    logic [15:0] done_count;
    logic [2:0]  pending;
    logic        idle;

    logic        t_valid;
    logic        t_ready;
    logic [31:0] t_addr;
    logic [31:0] t_head;
    logic [1:0]  t_busy;
    logic        t_done_valid;
    logic [31:0] t_done_addr;
    logic [1:0]  t_done_status;
    logic [15:0] t_done_count;
    logic [2:0]  t_pending;
    logic        t_idle;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt = 0;

    rip_pseudo_core_launcher u_dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .mem_head(mem_head), .busy(busy),
        .done_valid(done_valid), .done_addr(done_addr), .done_status(done_status),
        .done_count(done_count), .pending(pending), .idle(idle)
    );

    rip_pseudo_core_launcher #(.TIMEOUT_CYCLES(16)) u_dut_to (
        .clk(clk), .rstn(rstn),
        .cmd_valid(t_valid), .cmd_ready(t_ready), .cmd_addr(t_addr),
        .mem_head(t_head), .busy(t_busy),
        .done_valid(t_done_valid), .done_addr(t_done_addr), .done_status(t_done_status),
        .done_count(t_done_count), .pending(t_pending), .idle(t_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One push on the main instance; returns on the falling edge after the accepting edge.
    task automatic push(input logic [31:0] a);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Core model for one job: INIT for 2 cycles, n_rd cycles of read/write, then sleep.
    task automatic core_job(input logic [31:0] exp_addr, input int n_rd);
        int   waited = 0;
        logic bad = 1'b0;
        while (mem_head === ONES && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        check("launch_head", mem_head, exp_addr);
        busy = 2'b01;
        repeat (2) begin
            @(negedge clk);
            check("init_head_stable", mem_head, exp_addr);
        end
        busy = 2'b10;
        @(negedge clk);
        check("run_head_released", mem_head, ONES);
        for (int i = 1; i < n_rd; i++) begin
            busy = (i < n_rd / 2) ? 2'b10 : 2'b11;
            @(negedge clk);
            if (mem_head !== ONES || done_valid !== 1'b0) bad = 1'b1;
        end
        check("run_quiet", 32'(bad), 32'd0);
        busy = 2'b00;
        @(negedge clk);
        exp_cnt++;
        check("done_valid", 32'(done_valid), 32'd1);
        check("done_status_ok", 32'(done_status), 32'd0);
        check("done_addr", done_addr, exp_addr);
        check("done_count", 32'(done_count), 32'(exp_cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] bad_addrs [3];
        int   cyc;
        logic bad;

        rstn = 1'b0;
        cmd_valid = 1'b0; cmd_addr = '0; busy = 2'b00;
        t_valid = 1'b0;   t_addr = '0;   t_busy = 2'b00;
        repeat (2) @(negedge clk);

        // Reset state.
        check("rst_mem_head", mem_head, ONES);
        check("rst_done_valid", 32'(done_valid), 32'd0);
        check("rst_done_addr", done_addr, 32'd0);
        check("rst_done_status", 32'(done_status), 32'd0);
        check("rst_done_count", 32'(done_count), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(cmd_ready), 32'd1);
        check("post_rst_idle", 32'(idle), 32'd1);

        // A valid job with a 512-cycle read/write phase.
        push(32'h0000_1000);
        check("s1_pending", 32'(pending), 32'd1);
        core_job(32'h0000_1000, 512);
        @(negedge clk);
        check("s1_pulse_one_cycle", 32'(done_valid), 32'd0);
        check("s1_idle", 32'(idle), 32'd1);

        // Invalid addresses: low bits set, all-ones, and bit 9 set.
        bad_addrs[0] = 32'h0000_1004;
        bad_addrs[1] = ONES;
        bad_addrs[2] = 32'h0000_1200;
        for (int k = 0; k < 3; k++) begin
            push(bad_addrs[k]);
            check("bad_head_before", mem_head, ONES);
            @(negedge clk);
            check("bad_done_valid", 32'(done_valid), 32'd1);
            check("bad_done_status", 32'(done_status), 32'd2);
            check("bad_done_addr", done_addr, bad_addrs[k]);
            check("bad_done_count", 32'(done_count), 32'(exp_cnt));
            check("bad_head_after", mem_head, ONES);
            @(negedge clk);
            check("bad_pulse_one_cycle", 32'(done_valid), 32'd0);
        end

        // Five back-to-back pushes while the core is stalled in INIT.
        cmd_valid = 1'b1;
        for (int j = 0; j < 5; j++) begin
            cmd_addr = 32'(j + 1) << 12;
            if (j == 2) busy = 2'b01;
            @(negedge clk);
        end
        check("full_ready", 32'(cmd_ready), 32'd0);
        check("full_pending", 32'(pending), 32'd4);
        check("full_head", mem_head, 32'h0000_1000);
        cmd_addr = 32'h0000_6000;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("full_no_extra_push", 32'(pending), 32'd4);
        for (int j = 0; j < 5; j++) core_job(32'(j + 1) << 12, 4);
        check("full_drained", 32'(pending), 32'd0);

        // A push in the pop cycle right after a completion, with two jobs queued.
        cmd_valid = 1'b1;
        cmd_addr = 32'h0001_0000; @(negedge clk);
        cmd_addr = 32'h0002_0000; @(negedge clk);
        cmd_addr = 32'h0003_0000; @(negedge clk);
        cmd_valid = 1'b0;
        check("sim_pending_pre", 32'(pending), 32'd2);
        check("sim_head_j1", mem_head, 32'h0001_0000);
        busy = 2'b10;
        @(negedge clk);
        busy = 2'b00;
        @(negedge clk);
        exp_cnt++;
        check("sim_done_j1", done_addr, 32'h0001_0000);
        check("sim_pending_done", 32'(pending), 32'd2);
        cmd_valid = 1'b1;
        cmd_addr = 32'h0004_0000;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("sim_pending_through_pop", 32'(pending), 32'd2);
        check("sim_head_j2", mem_head, 32'h0002_0000);
        core_job(32'h0002_0000, 4);
        core_job(32'h0003_0000, 4);
        core_job(32'h0004_0000, 4);
        check("sim_empty", 32'(pending), 32'd0);

        // Timeout on the second instance, with the read phase stuck.
        t_busy = 2'b00;
        t_valid = 1'b1;
        t_addr = 32'h0000_1000; @(negedge clk);
        t_addr = 32'h0000_2000; @(negedge clk);
        t_valid = 1'b0;
        check("to_head_launch", t_head, 32'h0000_1000);
        t_busy = 2'b10;
        cyc = 0;
        while (t_done_valid !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("to_cycles", 32'(cyc), 32'd16);
        check("to_status", 32'(t_done_status), 32'd1);
        check("to_addr", t_done_addr, 32'h0000_1000);
        check("to_head", t_head, ONES);
        check("to_count", 32'(t_done_count), 32'd0);
        repeat (4) @(negedge clk);
        check("to_wait_head", t_head, ONES);
        check("to_wait_pending", 32'(t_pending), 32'd1);
        t_busy = 2'b00;
        @(negedge clk);
        check("to_next_head", t_head, 32'h0000_2000);
        t_busy = 2'b10;
        @(negedge clk);
        t_busy = 2'b00;
        @(negedge clk);
        check("to_next_status", 32'(t_done_status), 32'd0);
        check("to_next_addr", t_done_addr, 32'h0000_2000);
        check("to_next_count", 32'(t_done_count), 32'd1);

        // Reset in the middle of a job with two jobs still queued.
        busy = 2'b00;
        cmd_valid = 1'b1;
        cmd_addr = 32'h0000_7000; @(negedge clk);
        cmd_addr = 32'h0000_8000; @(negedge clk);
        cmd_addr = 32'h0000_9000; @(negedge clk);
        cmd_valid = 1'b0;
        busy = 2'b10;
        @(negedge clk);
        check("mid_pending_pre", 32'(pending), 32'd2);
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_head", mem_head, ONES);
        check("mid_rst_pending", 32'(pending), 32'd0);
        check("mid_rst_done_valid", 32'(done_valid), 32'd0);
        check("mid_rst_count", 32'(done_count), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        busy = 2'b00;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done_valid !== 1'b0 || mem_head !== ONES) bad = 1'b1;
        end
        check("mid_no_done_after", 32'(bad), 32'd0);
        check("mid_idle_after", 32'(idle), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rip_pseudo_core_launcher.md
RIP_PSEUDO_CORE_LAUNCHER -- requirements
Module: rip_pseudo_core_launcher

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning job address width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning job queue entries (power of 2, >=2).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65536, meaning max cycles per job before abort.
REQ-004 SHALL have port clk  input  1  meaning single clock; all logic is on the rising edge.
REQ-005 SHALL have port rstn  input  1  meaning asynchronous, active-low reset.
REQ-006 SHALL have port cmd_valid  input  1  meaning a job start address is offered.
REQ-007 SHALL have port cmd_ready  output  1  meaning the queue accepts a job.
REQ-008 SHALL have port cmd_addr  input  ADDR_WIDTH  meaning the job base address.
REQ-009 SHALL have port mem_head  output  ADDR_WIDTH  meaning the start address to the pseudo core; all-ones means no job.
REQ-010 SHALL have port busy  input  2  meaning core status: 00 sleep, 01 init, 10 read, 11 write.
REQ-011 SHALL have port done_valid  output  1  meaning a one-cycle job completion pulse.
REQ-012 SHALL have port done_addr  output  ADDR_WIDTH  meaning the address of the completed job.
REQ-013 SHALL have port done_status  output  2  meaning 00 ok, 01 timeout, 10 invalid address.
REQ-014 SHALL have port done_count  output  16  meaning the count of ok jobs, wrapping modulo 2^16.
REQ-015 SHALL have port pending  output  $clog2(FIFO_DEPTH)+1  meaning the number of queued jobs.
REQ-016 SHALL have port idle  output  1  meaning 1 when state is IDLE and the queue is empty.

Function
REQ-017 SHALL queue jobs in a FIFO: push on cmd_valid&&cmd_ready; cmd_ready = !full, derived from registered occupancy only.
REQ-018 SHALL pop and push in the same cycle when both occur, leaving pending unchanged.
REQ-019 SHALL make a job pushed in cycle N eligible for pop no earlier than cycle N+1.
REQ-020 SHALL implement states IDLE, LAUNCH, RUN.
REQ-021 SHALL, in IDLE with the queue non-empty and busy==00, pop the head, latch it, and zero the timeout counter.
REQ-022 SHALL treat a popped address as invalid if it is all-ones or cmd_addr[9:0]!=0 (core ORs cnt<<2 into bits [9:2]).
REQ-023 SHALL, for an invalid address, stay in IDLE, keep mem_head all-ones, and pulse done_valid with status 10 in the next cycle.
REQ-024 SHALL, for a valid address, drive mem_head=address from the next cycle and enter LAUNCH.
REQ-025 SHALL, in LAUNCH, hold mem_head stable until busy[1]==1; the core requires a stable head across INIT.
REQ-026 SHALL then drive mem_head all-ones in the next cycle and enter RUN.
REQ-027 SHALL, in RUN, on busy==00 pulse done_valid with status 00, increment done_count, and return to IDLE next cycle.
REQ-028 SHALL count cycles in LAUNCH+RUN; when the count reaches TIMEOUT_CYCLES-1, set mem_head all-ones, pulse done status 01, and go to IDLE.
REQ-029 SHALL leave done_count unchanged on timeout; IDLE waits for busy==00 before the next pop.
REQ-030 SHALL register done_addr/done_status, valid while done_valid=1 and held otherwise.
REQ-031 SHALL give timeout priority over completion if both occur in the same cycle.

Reset
REQ-032 SHALL, while rstn=0, force state=IDLE, an empty queue, mem_head all-ones, done_valid=0, done_addr=0, done_status=00, done_count=0, and pending=0.
REQ-033 SHALL show cmd_ready=1 and idle=1 from the first cycle after reset release.
REQ-034 SHALL drive mem_head all-ones asynchronously on a mid-job reset, dropping queued jobs with no done pulse.

Verification
REQ-035 SHALL cover: push 0x1000 with a core model (busy 00 to 01 for 2 cycles, 10/11 for 512 cycles, then 00) -> mem_head=0x1000 until busy=10, then all-ones; done status 00, addr 0x1000, done_count=1.
REQ-036 SHALL cover: push 0x1004 -> mem_head never leaves all-ones; done status 10, addr 0x1004, done_count unchanged.
REQ-037 SHALL cover: push 5 jobs back-to-back with FIFO_DEPTH=4 and core stalled at busy=01 -> cmd_ready=0 after 4 accepted entries (5th in LAUNCH); pending=4; release core -> jobs complete in order.
REQ-038 SHALL cover: TIMEOUT_CYCLES=16 with busy stuck at 10 -> done status 01 at cycle 16 after launch, mem_head all-ones; next job waits until busy=00.
REQ-039 SHALL cover: simultaneous push and completion with pending=2 -> pending stays 2 through the pop, and no job is lost or duplicated.
REQ-040 SHALL cover: assert rstn=0 during RUN -> mem_head all-ones immediately, pending=0, no done_valid.
